scoreboard_stall: RTL and testbench

Issue-side hazard controller for the ID stage: tracks destination registers of in-flight variable-latency operations (loads, multiply/divide) and holds IF/ID while a decoded instruction would read or overwrite one of them. It complements the EX-stage forwarding logic, which handles fixed-latency producers. It sits between the decoder and the ID/EX pipeline register, with a completion port from the writeback path.

---
 rtl/scoreboard_stall.sv | 133 +++++++++++++
 tb/tb_scoreboard_stall.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_stall.sv
// Issue-side hazard controller for the ID stage.
// Tracks destination registers of in-flight variable-latency operations and
// holds IF/ID while the decoded instruction would read or overwrite one of
// them, or while a single-cycle load in EX feeds it directly.
module scoreboard_stall #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int CNT_W           = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       IF_ID_rs,
   input  logic [4:0]       IF_ID_rt,
   input  logic             IF_ID_uses_rs,
   input  logic             IF_ID_uses_rt,
   input  logic             IF_ID_RegWrite,
   input  logic [4:0]       IF_ID_Write_register,
   input  logic             IF_ID_long_op,
   input  logic             ID_EX_MemRead,
   input  logic [4:0]       ID_EX_rt,
   input  logic             LU_done,
   input  logic [4:0]       LU_Write_register,
   output logic             Stall_ID,
   output logic             Bubble_EX,
   output logic [31:0]      pending,
   output logic [CNT_W-1:0] outstanding,
   output logic             sb_error,
   output logic [15:0]      stall_cycles
);

   logic [31:0]      r_pending;
   logic [CNT_W-1:0] r_outstanding;
   logic             r_sb_error;
   logic [15:0]      r_stall_cycles;

   logic        w_comp_rs;
   logic        w_comp_rt;
   logic        w_comp_dest;
   logic        w_raw_rs;
   logic        w_raw_rt;
   logic        w_waw;
   logic        w_full;
   logic        w_load_use;
   logic        w_stall;
   logic        w_long_dest;
   logic        w_issue;
   logic        w_valid_comp;
   logic        w_bad_comp;
   logic [31:0] w_set_mask;
   logic [31:0] w_clr_mask;

   // A completion in this cycle releases a reader or writer of the same
   // register, because the register file writes before it is read.
   assign w_comp_rs   = LU_done && (LU_Write_register == IF_ID_rs) && (IF_ID_rs != 5'd0);
   assign w_comp_rt   = LU_done && (LU_Write_register == IF_ID_rt) && (IF_ID_rt != 5'd0);
   assign w_comp_dest = LU_done && (LU_Write_register == IF_ID_Write_register)
                        && (IF_ID_Write_register != 5'd0);

   assign w_raw_rs = IF_ID_uses_rs && (IF_ID_rs != 5'd0) && r_pending[IF_ID_rs] && !w_comp_rs;
   assign w_raw_rt = IF_ID_uses_rt && (IF_ID_rt != 5'd0) && r_pending[IF_ID_rt] && !w_comp_rt;
   assign w_waw    = IF_ID_RegWrite && (IF_ID_Write_register != 5'd0)
                     && r_pending[IF_ID_Write_register] && !w_comp_dest;

   // A long op to a real register needs a tracking slot; a completion freeing
   // a slot in the same cycle lets it in.
   assign w_long_dest = IF_ID_long_op && IF_ID_RegWrite && (IF_ID_Write_register != 5'd0);
   assign w_full      = w_long_dest && (r_outstanding == CNT_W'(MAX_OUTSTANDING))
                        && !(LU_done && r_pending[LU_Write_register]);

   assign w_load_use = ID_EX_MemRead && (ID_EX_rt != 5'd0)
                       && ((IF_ID_uses_rs && (IF_ID_rs == ID_EX_rt))
                        || (IF_ID_uses_rt && (IF_ID_rt == ID_EX_rt)));

   assign w_stall = w_raw_rs | w_raw_rt | w_waw | w_full | w_load_use;

   assign w_issue      = w_long_dest && !w_stall;
   assign w_valid_comp = LU_done && (LU_Write_register != 5'd0) && r_pending[LU_Write_register];
   assign w_bad_comp   = LU_done && !w_valid_comp;

   // Build one-hot set/clear masks for the pending vector from this cycle's
   // issue and completion events.
   always_comb begin
      w_set_mask = 32'd0;
      w_clr_mask = 32'd0;
      if (w_issue)
         w_set_mask[IF_ID_Write_register] = 1'b1;
      if (w_valid_comp)
         w_clr_mask[LU_Write_register] = 1'b1;
   end

   // Pending bits: clear completions first, then set the new issue, so an
   // issue to a register completing this cycle leaves it pending.
   always_ff @(posedge clk) begin
      if (reset)
         r_pending <= 32'd0;
      else
         r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
   end

   // Outstanding count follows the pending population; simultaneous issue
   // and completion cancel out.
   always_ff @(posedge clk) begin
      if (reset)
         r_outstanding <= '0;
      else if (w_issue && !w_valid_comp)
         r_outstanding <= r_outstanding + CNT_W'(1);
      else if (!w_issue && w_valid_comp)
         r_outstanding <= r_outstanding - CNT_W'(1);
   end

   // Sticky error for completions that match no tracked register.
   always_ff @(posedge clk) begin
      if (reset)
         r_sb_error <= 1'b0;
      else if (w_bad_comp)
         r_sb_error <= 1'b1;
   end

   // Saturating count of cycles spent stalled.
   always_ff @(posedge clk) begin
      if (reset)
         r_stall_cycles <= 16'd0;
      else if (w_stall && (r_stall_cycles != 16'hFFFF))
         r_stall_cycles <= r_stall_cycles + 16'd1;
   end

   assign Stall_ID     = w_stall;
   assign Bubble_EX    = w_stall;
   assign pending      = r_pending;
   assign outstanding  = r_outstanding;
   assign sb_error     = r_sb_error;
   assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_scoreboard_stall.sv
// Self-checking bench for scoreboard_stall: directed scenarios with literal
// expectations, then randomized traffic and a long stall run, all compared
// every cycle against a behavioural model of the register scoreboard.
module tb_scoreboard_stall;

   localparam int MAX_OUT = 4;
   localparam int CW      = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic [4:0]    IF_ID_rs, IF_ID_rt, IF_ID_Write_register, ID_EX_rt, LU_Write_register;
   logic          IF_ID_uses_rs, IF_ID_uses_rt, IF_ID_RegWrite, IF_ID_long_op;
   logic          ID_EX_MemRead, LU_done;
   logic          Stall_ID, Bubble_EX, sb_error;
   logic [31:0]   pending;
   logic [CW-1:0] outstanding;
   logic [15:0]   stall_cycles;

   int checks   = 0;
   int failures = 0;

   bit mPend [32];
   bit mErr;
   int mCnt;

   scoreboard_stall #(.MAX_OUTSTANDING(MAX_OUT), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
      .IF_ID_uses_rs(IF_ID_uses_rs), .IF_ID_uses_rt(IF_ID_uses_rt),
      .IF_ID_RegWrite(IF_ID_RegWrite), .IF_ID_Write_register(IF_ID_Write_register),
      .IF_ID_long_op(IF_ID_long_op),
      .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rt(ID_EX_rt),
      .LU_done(LU_done), .LU_Write_register(LU_Write_register),
      .Stall_ID(Stall_ID), .Bubble_EX(Bubble_EX), .pending(pending),
      .outstanding(outstanding), .sb_error(sb_error), .stall_cycles(stall_cycles)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   function automatic int modelCount();
      int n = 0;
      for (int i = 0; i < 32; i++) n += mPend[i];
      return n;
   endfunction

   function automatic logic [31:0] modelPendVec();
      logic [31:0] v = '0;
      for (int i = 0; i < 32; i++) v[i] = mPend[i];
      return v;
   endfunction

   function automatic bit releasedBy(input logic [4:0] r);
      return LU_done && (LU_Write_register == r) && (r != 0);
   endfunction

   function automatic bit modelStall();
      bit hazard = 0;
      if (IF_ID_uses_rs && IF_ID_rs != 0 && mPend[IF_ID_rs] && !releasedBy(IF_ID_rs)) hazard = 1;
      if (IF_ID_uses_rt && IF_ID_rt != 0 && mPend[IF_ID_rt] && !releasedBy(IF_ID_rt)) hazard = 1;
      if (IF_ID_RegWrite && IF_ID_Write_register != 0 && mPend[IF_ID_Write_register]
          && !releasedBy(IF_ID_Write_register)) hazard = 1;
      if (IF_ID_long_op && IF_ID_RegWrite && IF_ID_Write_register != 0 && modelCount() == MAX_OUT
          && !(LU_done && mPend[LU_Write_register])) hazard = 1;
      if (ID_EX_MemRead && ID_EX_rt != 0
          && ((IF_ID_uses_rs && IF_ID_rs == ID_EX_rt) || (IF_ID_uses_rt && IF_ID_rt == ID_EX_rt)))
         hazard = 1;
      return hazard;
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 32; i++) mPend[i] = 0;
      mErr = 0;
      mCnt = 0;
   endtask

   // Advance the model across one rising edge given the current inputs.
   task automatic modelUpdate(input bit st);
      bit validComp;
      if (reset) begin
         modelReset();
         return;
      end
      validComp = LU_done && LU_Write_register != 0 && mPend[LU_Write_register];
      if (LU_done && !validComp) mErr = 1;
      if (validComp) mPend[LU_Write_register] = 0;
      if (IF_ID_long_op && IF_ID_RegWrite && IF_ID_Write_register != 0 && !st)
         mPend[IF_ID_Write_register] = 1;
      if (st && mCnt < 16'hFFFF) mCnt++;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 30)
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   task automatic compareAll(input bit st);
      checkOutput("Stall_ID", {31'd0, Stall_ID}, {31'd0, st});
      checkOutput("Bubble_EX", {31'd0, Bubble_EX}, {31'd0, st});
      checkOutput("pending", pending, modelPendVec());
      checkOutput("outstanding", 32'(outstanding), 32'(modelCount()));
      checkOutput("sb_error", {31'd0, sb_error}, {31'd0, mErr});
      checkOutput("stall_cycles", {16'd0, stall_cycles}, 32'(mCnt));
   endtask

   // Hold current inputs for one cycle: compare at the falling edge, then
   // step the model and move just past the next rising edge.
   task automatic applyStimulus(input int expStall);
      bit st;
      #4;
      st = modelStall();
      if (expStall >= 0) checkOutput("stall_literal", {31'd0, Stall_ID}, 32'(expStall));
      compareAll(st);
      modelUpdate(st);
      @(posedge clk);
      #1;
   endtask

   task automatic setIdle();
      reset = 0;
      IF_ID_rs = 0; IF_ID_rt = 0; IF_ID_uses_rs = 0; IF_ID_uses_rt = 0;
      IF_ID_RegWrite = 0; IF_ID_Write_register = 0; IF_ID_long_op = 0;
      ID_EX_MemRead = 0; ID_EX_rt = 0; LU_done = 0; LU_Write_register = 0;
   endtask

   task automatic issueLong(input logic [4:0] r, input int expStall);
      setIdle();
      IF_ID_long_op = 1; IF_ID_RegWrite = 1; IF_ID_Write_register = r;
      applyStimulus(expStall);
   endtask

   task automatic doReset();
      setIdle();
      reset = 1;
      applyStimulus(0);
      reset = 0;
   endtask

   task automatic randomCycle();
      int q[$];
      setIdle();
      reset = ($urandom_range(0, 199) == 0);
      IF_ID_rs = 5'($urandom_range(0, 7));
      IF_ID_rt = 5'($urandom_range(0, 7));
      IF_ID_uses_rs = 1'($urandom);
      IF_ID_uses_rt = 1'($urandom);
      IF_ID_RegWrite = 1'($urandom);
      IF_ID_Write_register = 5'($urandom_range(0, 9));
      IF_ID_long_op = ($urandom_range(0, 2) != 0);
      ID_EX_MemRead = ($urandom_range(0, 3) == 0);
      ID_EX_rt = 5'($urandom_range(0, 7));
      LU_done = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < 32; i++) if (mPend[i]) q.push_back(i);
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
         LU_Write_register = 5'(q[$urandom_range(0, q.size() - 1)]);
      else
         LU_Write_register = 5'($urandom_range(0, 9));
      applyStimulus(-1);
   endtask

   initial begin
      setIdle();
      reset = 1;
      repeat (2) @(posedge clk);
      #1;
      modelReset();
      reset = 0;

      checkOutput("reset_pending", pending, 32'd0);
      checkOutput("reset_outstanding", 32'(outstanding), 32'd0);
      checkOutput("reset_sb_error", {31'd0, sb_error}, 32'd0);
      checkOutput("reset_stall_cycles", {16'd0, stall_cycles}, 32'd0);

      // RAW on a long op, released in the completion cycle
      issueLong(5, 0);
      checkOutput("raw_pending_set", pending, 32'h0000_0020);
      checkOutput("raw_outstanding_1", 32'(outstanding), 32'd1);
      setIdle();
      IF_ID_uses_rs = 1; IF_ID_rs = 5;
      repeat (3) applyStimulus(1);
      LU_done = 1; LU_Write_register = 5;
      applyStimulus(0);
      checkOutput("raw_pending_clear", pending, 32'd0);
      checkOutput("raw_outstanding_0", 32'(outstanding), 32'd0);
      checkOutput("raw_stall_count", {16'd0, stall_cycles}, 32'd3);

      // Load-use: one cycle, then the load leaves EX
      setIdle();
      ID_EX_MemRead = 1; ID_EX_rt = 8; IF_ID_uses_rt = 1; IF_ID_rt = 8;
      applyStimulus(1);
      ID_EX_MemRead = 0;
      applyStimulus(0);
      ID_EX_MemRead = 1; ID_EX_rt = 0; IF_ID_rt = 0;
      applyStimulus(0);

      // Full table, slot freed by a same-cycle completion
      doReset();
      for (int r = 1; r <= 4; r++) issueLong(5'(r), 0);
      issueLong(6, 1);
      checkOutput("full_outstanding_4", 32'(outstanding), 32'd4);
      setIdle();
      IF_ID_long_op = 1; IF_ID_RegWrite = 1; IF_ID_Write_register = 6;
      LU_done = 1; LU_Write_register = 2;
      applyStimulus(0);
      checkOutput("full_outstanding_kept", 32'(outstanding), 32'd4);
      checkOutput("full_pending_set", pending, 32'h0000_005A);

      // WAW, released by a same-cycle completion of the same register
      doReset();
      issueLong(7, 0);
      issueLong(7, 1);
      setIdle();
      IF_ID_long_op = 1; IF_ID_RegWrite = 1; IF_ID_Write_register = 7;
      LU_done = 1; LU_Write_register = 7;
      applyStimulus(0);
      checkOutput("waw_pending_7", pending, 32'h0000_0080);
      checkOutput("waw_outstanding_1", 32'(outstanding), 32'd1);

      // Spurious completion sets the sticky error only
      setIdle();
      LU_done = 1; LU_Write_register = 9;
      applyStimulus(0);
      checkOutput("err_set", {31'd0, sb_error}, 32'd1);
      checkOutput("err_pending_kept", pending, 32'h0000_0080);
      checkOutput("err_outstanding_kept", 32'(outstanding), 32'd1);
      setIdle();
      applyStimulus(0);
      checkOutput("err_sticky", {31'd0, sb_error}, 32'd1);
      doReset();
      checkOutput("err_cleared", {31'd0, sb_error}, 32'd0);

      // Reset in the middle of activity
      issueLong(1, 0);
      issueLong(2, 0);
      issueLong(3, 0);
      setIdle();
      IF_ID_uses_rs = 1; IF_ID_rs = 1;
      repeat (5) applyStimulus(1);
      checkOutput("mid_stall_count", {16'd0, stall_cycles}, 32'd5);
      doReset();
      checkOutput("mid_pending", pending, 32'd0);
      checkOutput("mid_outstanding", 32'(outstanding), 32'd0);
      checkOutput("mid_stall_cycles", {16'd0, stall_cycles}, 32'd0);
      checkOutput("mid_stall_id", {31'd0, Stall_ID}, 32'd0);
      setIdle();
      LU_done = 1; LU_Write_register = 1;
      applyStimulus(0);
      checkOutput("mid_late_comp_err", {31'd0, sb_error}, 32'd1);

      // Long-op destination r0 is never tracked
      doReset();
      issueLong(0, 0);
      checkOutput("r0_untracked", pending, 32'd0);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) randomCycle();

      // Saturation of the stall counter
      doReset();
      setIdle();
      ID_EX_MemRead = 1; ID_EX_rt = 3; IF_ID_uses_rs = 1; IF_ID_rs = 3;
      for (int c = 0; c < 65540; c++) applyStimulus(1);
      checkOutput("stall_saturated", {16'd0, stall_cycles}, 32'h0000_FFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
